// File: rtl/mem_port_arbiter.sv
// Unified memory bus arbiter between instruction fetch and the LSU.
// One transaction outstanding; fetches can be killed by pipeline flush.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic            o_if_vld,
    output logic [XLEN-1:0] o_if_inst,
    input  logic            i_flush,
    input  logic            i_ls_req,
    input  logic            i_ls_we,
    input  logic [XLEN-1:0] i_ls_addr,
    input  logic [XLEN-1:0] i_ls_wdata,
    input  logic [3:0]      i_ls_wstrb,
    output logic            o_ls_ack,
    output logic            o_ls_vld,
    output logic [XLEN-1:0] o_ls_rdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvld,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [1:0] state;
    logic       owner_ls;
    logic       kill;
    logic [3:0] streak;
    logic       idle;
    logic       force_if;
    logic       if_win;
    logic       ls_win;

    // IDLE arbitration: data wins unless fetch has been starved too long
    always_comb begin
        idle     = (state == S_IDLE);
        force_if = i_if_req && (streak == STREAK_MAX);
        if_win   = idle && i_if_req && !i_flush && (!i_ls_req || force_if);
        ls_win   = idle && i_ls_req && !if_win;
    end

    assign o_if_ack  = if_win;
    assign o_ls_ack  = ls_win;
    assign o_mem_req = (state == S_REQ);

    // Transaction sequencer: latch winner, hold bus request, return data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner_ls    <= 1'b0;
            kill        <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            o_if_vld    <= 1'b0;
            o_if_inst   <= '0;
            o_ls_vld    <= 1'b0;
            o_ls_rdata  <= '0;
        end else begin
            o_if_vld <= 1'b0;
            o_ls_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_win) begin
                        state       <= S_REQ;
                        owner_ls    <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= '0;
                        o_mem_wstrb <= '0;
                    end else if (ls_win) begin
                        state       <= S_REQ;
                        owner_ls    <= 1'b1;
                        o_mem_we    <= i_ls_we;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_wstrb <= i_ls_wstrb;
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt)
                        state <= S_RESP;
                    if (!owner_ls && i_flush)
                        kill <= 1'b1;
                end
                S_RESP: begin
                    if (i_mem_rvld) begin
                        state <= S_IDLE;
                        kill  <= 1'b0;
                        if (owner_ls) begin
                            o_ls_vld   <= 1'b1;
                            o_ls_rdata <= i_mem_rdata;
                        end else if (!(kill || i_flush)) begin
                            o_if_vld  <= 1'b1;
                            o_if_inst <= i_mem_rdata;
                        end
                    end else if (!owner_ls && i_flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Count contested data grants; a fetch grant resets the streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            streak <= '0;
        else if (if_win)
            streak <= '0;
        else if (ls_win && i_if_req && streak != STREAK_MAX)
            streak <= streak + 4'd1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reactive memory model plus
// scoreboard queues filled at ack and drained at vld.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        o_if_ack, o_if_vld;
    logic [31:0] o_if_inst;
    logic        i_flush = 1'b0;
    logic        i_ls_req = 1'b0;
    logic        i_ls_we = 1'b0;
    logic [31:0] i_ls_addr = '0;
    logic [31:0] i_ls_wdata = '0;
    logic [3:0]  i_ls_wstrb = '0;
    logic        o_ls_ack, o_ls_vld;
    logic [31:0] o_ls_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_gnt, i_mem_rvld;
    logic [31:0] i_mem_rdata;

    logic gnt_en = 1'b1;
    logic rvld_en = 1'b1;
    logic stray_rvld = 1'b0;
    logic pending;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail = 0;
    int if_vld_cnt = 0;
    int ls_vld_cnt = 0;

    logic [31:0] if_q[$];
    logic [32:0] ls_q[$];
    bit          glog[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_ack(o_if_ack), .o_if_vld(o_if_vld), .o_if_inst(o_if_inst),
        .i_flush(i_flush),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
        .o_ls_ack(o_ls_ack), .o_ls_vld(o_ls_vld), .o_ls_rdata(o_ls_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvld(i_mem_rvld),
        .i_mem_rdata(i_mem_rdata)
    );

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a == 32'h10)
            return 32'h0040_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: grant when enabled, answer the cycle after grant
    assign i_mem_gnt   = o_mem_req && gnt_en;
    assign i_mem_rvld  = (pending && rvld_en) || stray_rvld;
    assign i_mem_rdata = rd_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            rd_data <= '0;
        end else if (o_mem_req && i_mem_gnt) begin
            pending <= 1'b1;
            rd_data <= exp_rd(o_mem_addr);
        end else if (pending && i_mem_rvld) begin
            pending <= 1'b0;
        end
    end

    // Scoreboard: push expectation at ack, compare at vld
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_if_ack) begin
                if_q.push_back(exp_rd(i_if_addr));
                glog.push_back(1'b1);
            end
            if (o_ls_ack) begin
                ls_q.push_back({i_ls_we, exp_rd(i_ls_addr)});
                glog.push_back(1'b0);
            end
            if (o_if_vld) begin
                if_vld_cnt++;
                n_tests++;
                if (if_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL if_vld_unexpected: got inst %h want no vld", o_if_inst);
                end else begin
                    logic [31:0] e;
                    e = if_q.pop_front();
                    if (o_if_inst !== e) begin
                        n_fail++;
                        $display("FAIL if_inst: got %h want %h", o_if_inst, e);
                    end
                end
            end
            if (o_ls_vld) begin
                ls_vld_cnt++;
                if (ls_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ls_vld_unexpected: got rdata %h want no vld", o_ls_rdata);
                end else begin
                    logic [32:0] e;
                    e = ls_q.pop_front();
                    if (!e[32]) begin
                        n_tests++;
                        if (o_ls_rdata !== e[31:0]) begin
                            n_fail++;
                            $display("FAIL ls_rdata: got %h want %h", o_ls_rdata, e[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({o_if_ack, o_if_vld, o_ls_ack, o_ls_vld, o_mem_req, o_mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {o_if_ack, o_if_vld, o_ls_ack, o_ls_vld, o_mem_req, o_mem_we});
        end
        n_tests++;
        if ({o_mem_addr, o_mem_wdata, o_mem_wstrb} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h want 0", {o_mem_addr, o_mem_wdata, o_mem_wstrb});
        end
        n_tests++;
        if ({o_if_inst, o_ls_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {o_if_inst, o_ls_rdata});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(posedge clk); #1;
        i_if_req  = 1'b1;
        i_if_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (o_if_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_ack: got %b want 1", o_if_ack);
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL fetch_bus: got %h want %h",
                     {o_mem_req, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 32'h10});
        end
        @(negedge clk);
        n_tests++;
        if (o_if_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_early_vld: got %b want 0", o_if_vld);
        end
        @(negedge clk);
        n_tests++;
        if (o_if_vld !== 1'b1 || o_if_inst !== 32'h0040_0093) begin
            n_fail++;
            $display("FAIL fetch_vld: got %b/%h want 1/00400093", o_if_vld, o_if_inst);
        end
    endtask

    task automatic test_contention();
        int ls0;
        bit got;
        ls0 = ls_vld_cnt;
        got = 1'b0;
        @(posedge clk); #1;
        i_ls_req   = 1'b1;
        i_ls_we    = 1'b1;
        i_ls_addr  = 32'h2000;
        i_ls_wdata = 32'hDEAD_BEEF;
        i_ls_wstrb = 4'hF;
        i_if_req   = 1'b1;
        i_if_addr  = 32'h40;
        @(negedge clk);
        n_tests++;
        if ({o_ls_ack, o_if_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL contend_ack: got ls/if %b want 10", {o_ls_ack, o_if_ack});
        end
        @(posedge clk); #1;
        i_ls_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb} !==
            {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL contend_bus: got %h want %h",
                     {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb},
                     {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF});
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_if_ack;
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL contend_if_ack: got none want ack within 20 cycles");
        end
        for (int i = 0; i < 30 && (if_q.size() + ls_q.size()) != 0; i++)
            @(negedge clk);
        n_tests++;
        if (ls_vld_cnt - ls0 !== 1) begin
            n_fail++;
            $display("FAIL contend_ls_vld: got %0d pulses want 1", ls_vld_cnt - ls0);
        end
    endtask

    task automatic test_starvation();
        bit la, ia;
        glog.delete();
        @(posedge clk); #1;
        i_ls_req  = 1'b1;
        i_ls_we   = 1'b0;
        i_ls_addr = 32'h100;
        i_if_req  = 1'b1;
        i_if_addr = 32'h200;
        for (int i = 0; i < 200 && glog.size() < 10; i++) begin
            @(negedge clk);
            la = o_ls_ack;
            ia = o_if_ack;
            @(posedge clk); #1;
            if (la) i_ls_addr = i_ls_addr + 32'd4;
            if (ia) i_if_addr = i_if_addr + 32'd4;
        end
        i_ls_req = 1'b0;
        i_if_req = 1'b0;
        n_tests++;
        if (glog.size() < 10) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants want 10", glog.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_tests++;
                if (glog[k] !== (k % 5 == 4)) begin
                    n_fail++;
                    $display("FAIL starve_order[%0d]: got if=%b want if=%b",
                             k, glog[k], (k % 5 == 4));
                end
            end
        end
        for (int i = 0; i < 30 && (if_q.size() + ls_q.size()) != 0; i++)
            @(negedge clk);
        n_tests++;
        if (if_q.size() + ls_q.size() != 0) begin
            n_fail++;
            $display("FAIL starve_drain: got %0d pending want 0", if_q.size() + ls_q.size());
        end
    endtask

    task automatic test_flush();
        bit seen;
        int if0;
        seen    = 1'b0;
        rvld_en = 1'b0;
        @(posedge clk); #1;
        i_if_req  = 1'b1;
        i_if_addr = 32'h80;
        @(negedge clk);
        n_tests++;
        if (o_if_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ack: got %b want 1", o_if_ack);
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        for (int i = 0; i < 10 && !pending; i++)
            @(negedge clk);
        @(posedge clk); #1;
        i_flush = 1'b1;
        if (if_q.size() != 0)
            void'(if_q.pop_back());
        @(posedge clk); #1;
        i_flush = 1'b0;
        rvld_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_if_vld) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_suppress: got vld=1 want 0");
        end
        if0 = if_vld_cnt;
        @(posedge clk); #1;
        i_if_req  = 1'b1;
        i_if_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (o_if_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_next_ack: got %b want 1", o_if_ack);
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        for (int i = 0; i < 10 && if_q.size() != 0; i++)
            @(negedge clk);
        n_tests++;
        if (if_vld_cnt - if0 !== 1) begin
            n_fail++;
            $display("FAIL flush_next_vld: got %0d pulses want 1", if_vld_cnt - if0);
        end
    endtask

    task automatic test_stall();
        bit got;
        got    = 1'b0;
        gnt_en = 1'b0;
        @(posedge clk); #1;
        i_ls_req   = 1'b1;
        i_ls_we    = 1'b1;
        i_ls_addr  = 32'h3000;
        i_ls_wdata = 32'h1234_5678;
        i_ls_wstrb = 4'h3;
        @(negedge clk);
        n_tests++;
        if (o_ls_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ack: got %b want 1", o_ls_ack);
        end
        @(posedge clk); #1;
        i_ls_req   = 1'b0;
        i_ls_wdata = 32'h0;
        i_if_req   = 1'b1;
        i_if_addr  = 32'h44;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
                 o_if_ack, o_ls_ack} !==
                {1'b1, 1'b1, 32'h3000, 32'h1234_5678, 4'h3, 2'b00}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h want %h", c,
                         {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
                          o_if_ack, o_ls_ack},
                         {1'b1, 1'b1, 32'h3000, 32'h1234_5678, 4'h3, 2'b00});
            end
        end
        @(posedge clk); #1;
        gnt_en = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_if_ack;
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL stall_if_ack: got none want ack within 20 cycles");
        end
        for (int i = 0; i < 30 && (if_q.size() + ls_q.size()) != 0; i++)
            @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit seen;
        seen    = 1'b0;
        rvld_en = 1'b0;
        @(posedge clk); #1;
        i_if_req  = 1'b1;
        i_if_addr = 32'h60;
        @(negedge clk);
        @(posedge clk); #1;
        i_if_req = 1'b0;
        for (int i = 0; i < 10 && !pending; i++)
            @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        if_q.delete();
        @(negedge clk);
        n_tests++;
        if ({o_if_ack, o_if_vld, o_if_inst, o_ls_ack, o_ls_vld, o_ls_rdata,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outs: got %h want 0",
                     {o_if_ack, o_if_vld, o_if_inst, o_ls_ack, o_ls_vld, o_ls_rdata,
                      o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb});
        end
        @(posedge clk); #1;
        rst_n      = 1'b1;
        rvld_en    = 1'b1;
        stray_rvld = 1'b1;
        @(posedge clk); #1;
        stray_rvld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_if_vld || o_ls_vld || o_mem_req) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midop_stray: got activity after stray rvld want none");
        end
        @(posedge clk); #1;
        i_if_req  = 1'b1;
        i_if_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (o_if_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_idle_ack: got %b want 1", o_if_ack);
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
        for (int i = 0; i < 10 && if_q.size() != 0; i++)
            @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_flush();
        test_stall();
        test_reset_midop();
        repeat (3) @(negedge clk);
        n_tests++;
        if (if_q.size() + ls_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got %0d pending want 0", if_q.size() + ls_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
